// File: rtl/riscv_core_rob_ctrl_pkg.sv
// rtl/riscv_core_rob_ctrl_pkg.sv - shared sizing for the reorder-buffer control slice
package riscv_core_rob_ctrl_pkg;

    localparam int ENTRIES = 16;
    localparam int SLOT_W  = 4;
    localparam int REG_W   = 5;

    // Occupancy value at which the ROB refuses further allocation.
    localparam logic [SLOT_W:0] COUNT_FULL = (SLOT_W+1)'(ENTRIES);

    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [REG_W-1:0]  reg_addr_t;

endpackage

// File: rtl/riscv_core_rob_ctrl_if.sv
// rtl/riscv_core_rob_ctrl_if.sv - issue/writeback/commit signal bundle around the ROB control
interface riscv_core_rob_ctrl_if;
    import riscv_core_rob_ctrl_pkg::*;

    // issue side allocation
    logic                alloc_val;
    logic                alloc_wen;
    reg_addr_t           alloc_waddr;
    logic                alloc_rdy;
    slot_t               alloc_slot;

    // writeback fill
    logic                fill_val;
    slot_t               fill_slot;

    // in-order retire towards the datapath
    logic                rob_commit_wen_Chl;
    slot_t               rob_commit_slot_Chl;
    reg_addr_t           rob_commit_waddr_Chl;
    logic                commit_val;

    // operand lookups for bypass / stall decisions
    reg_addr_t           src0_addr;
    reg_addr_t           src1_addr;
    logic                src0_hit;
    logic                src1_hit;
    slot_t               src0_slot;
    slot_t               src1_slot;
    logic                src0_rdy;
    logic                src1_rdy;

    // occupancy and status
    logic [SLOT_W:0]     count;
    logic                empty;
    logic                full;
    logic                fill_err;

    modport master (
        output alloc_val, alloc_wen, alloc_waddr, fill_val, fill_slot,
               src0_addr, src1_addr,
        input  alloc_rdy, alloc_slot, rob_commit_wen_Chl, rob_commit_slot_Chl,
               rob_commit_waddr_Chl, commit_val, src0_hit, src1_hit,
               src0_slot, src1_slot, src0_rdy, src1_rdy, count, empty, full,
               fill_err
    );

    modport slave (
        input  alloc_val, alloc_wen, alloc_waddr, fill_val, fill_slot,
               src0_addr, src1_addr,
        output alloc_rdy, alloc_slot, rob_commit_wen_Chl, rob_commit_slot_Chl,
               rob_commit_waddr_Chl, commit_val, src0_hit, src1_hit,
               src0_slot, src1_slot, src0_rdy, src1_rdy, count, empty, full,
               fill_err
    );

endinterface

// File: rtl/riscv_core_rob_lookup.sv
// rtl/riscv_core_rob_lookup.sv - age-ordered search for the youngest live producer of a register
module riscv_core_rob_lookup
    import riscv_core_rob_ctrl_pkg::*;
(
    input  logic [ENTRIES-1:0]            valid,
    input  logic [ENTRIES-1:0]            wen,
    input  logic [ENTRIES-1:0][REG_W-1:0] waddr,
    input  slot_t                         head,
    input  reg_addr_t                     src,
    output logic                          hit,
    output slot_t                         slot
);

    slot_t idx;

    // Walk from oldest (head) to youngest; every later match overrides, so the youngest wins.
    always_comb begin
        hit  = 1'b0;
        slot = '0;
        idx  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            idx = head + SLOT_W'(i);
            if ((src != '0) && valid[idx] && wen[idx] && (waddr[idx] == src)) begin
                hit  = 1'b1;
                slot = idx;
            end
        end
    end

endmodule

// File: rtl/riscv_core_rob_ctrl.sv
// rtl/riscv_core_rob_ctrl.sv - reorder-buffer slot allocation, fill tracking and in-order retire
module riscv_core_rob_ctrl
    import riscv_core_rob_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    riscv_core_rob_ctrl_if.slave rob
);

    slot_t                         head_q;
    slot_t                         tail_q;
    logic [SLOT_W:0]               count_q;
    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0]            filled_q;
    logic [ENTRIES-1:0]            wen_q;
    logic [ENTRIES-1:0][REG_W-1:0] waddr_q;
    logic                          fill_err_q;

    logic alloc_fire;
    logic commit_fire;
    logic fill_ok;
    logic full_w;

    // Full/empty come from the occupancy counter; pointers alone cannot tell them apart.
    assign full_w      = (count_q == COUNT_FULL);
    assign alloc_fire  = rob.alloc_val && !full_w;
    assign commit_fire = valid_q[head_q] && filled_q[head_q];
    assign fill_ok     = valid_q[rob.fill_slot] && !filled_q[rob.fill_slot];

    assign rob.alloc_rdy            = !full_w;
    assign rob.alloc_slot           = tail_q;
    assign rob.commit_val           = commit_fire;
    assign rob.rob_commit_slot_Chl  = head_q;
    assign rob.rob_commit_waddr_Chl = waddr_q[head_q];
    // x0 is never written even when the retiring instruction claims a destination.
    assign rob.rob_commit_wen_Chl   = commit_fire && wen_q[head_q] && (waddr_q[head_q] != '0);
    assign rob.count                = count_q;
    assign rob.empty                = (count_q == '0);
    assign rob.full                 = full_w;
    assign rob.fill_err             = fill_err_q;

    // Head/tail advance on retire/allocate; occupancy tracks both in the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                tail_q <= tail_q + SLOT_W'(1);
            end
            if (commit_fire) begin
                head_q <= head_q + SLOT_W'(1);
            end
            count_q <= count_q + {{SLOT_W{1'b0}}, alloc_fire} - {{SLOT_W{1'b0}}, commit_fire};
        end
    end

    // Per-entry state: retire clears head, fill marks a live unfilled slot, allocate seeds tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            filled_q <= '0;
            wen_q    <= '0;
            waddr_q  <= '0;
        end else begin
            if (commit_fire) begin
                valid_q[head_q]  <= 1'b0;
                filled_q[head_q] <= 1'b0;
            end
            if (rob.fill_val && fill_ok) begin
                filled_q[rob.fill_slot] <= 1'b1;
            end
            if (alloc_fire) begin
                valid_q[tail_q]  <= 1'b1;
                filled_q[tail_q] <= 1'b0;
                wen_q[tail_q]    <= rob.alloc_wen;
                waddr_q[tail_q]  <= rob.alloc_waddr;
            end
        end
    end

    // Sticky flag for fills aimed at a dead or already-completed slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_err_q <= 1'b0;
        end else if (rob.fill_val && !fill_ok) begin
            fill_err_q <= 1'b1;
        end
    end

    riscv_core_rob_lookup u_lookup_src0 (
        .valid (valid_q),
        .wen   (wen_q),
        .waddr (waddr_q),
        .head  (head_q),
        .src   (rob.src0_addr),
        .hit   (rob.src0_hit),
        .slot  (rob.src0_slot)
    );

    riscv_core_rob_lookup u_lookup_src1 (
        .valid (valid_q),
        .wen   (wen_q),
        .waddr (waddr_q),
        .head  (head_q),
        .src   (rob.src1_addr),
        .hit   (rob.src1_hit),
        .slot  (rob.src1_slot)
    );

    // Lookup slot is 0 on a miss, so readiness must be gated by the hit.
    assign rob.src0_rdy = rob.src0_hit && filled_q[rob.src0_slot];
    assign rob.src1_rdy = rob.src1_hit && filled_q[rob.src1_slot];

endmodule
